// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: iterative multiply/divide sequencer and owner of the HI/LO registers.
// Divide is restoring radix-2 (32 cycles). Multiply is shift-add (32 cycles) unless
// MDU_FAST_MUL_EN is defined, in which case it is a single-cycle product.
// Stalls EX while an HI/LO-dependent instruction meets a busy unit.
module mdu_hilo_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [3:0]  div_mul_control,
  input  logic [1:0]  hi_lo_control,
  input  logic [1:0]  mf_sel,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;   // mul: product/multiplier; div: {remainder, quotient}
  logic [31:0] b_q, b_d;       // multiplicand or divisor magnitude
  logic [31:0] raw_q, raw_d;   // raw dividend, returned in HI on divide by zero
  logic        neg_q, neg_d;   // negate product/quotient
  logic        rneg_q, rneg_d; // negate remainder
  logic        dz_q, dz_d;     // divide by zero
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        any_op;
  logic        accept;
  logic        op_div;
  logic        op_signed;
  logic [31:0] mag1;
  logic [31:0] mag2;

  // Divide step: shift {rem, quot} left and try to subtract the divisor.
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] div_next;
  logic [31:0] quot_res;
  logic [31:0] rem_res;

`ifdef MDU_FAST_MUL_EN
  logic [63:0] ext1;
  logic [63:0] ext2;
`else
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] mul_res;
`endif

  assign any_op = |div_mul_control;
  assign busy   = (state_q != StIdle);
  assign accept = issue_valid && any_op && !busy;
  assign stall  = issue_valid && busy && (any_op || (|hi_lo_control) || (|mf_sel));
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Priority div > divu > mult > multu; only div and mult are signed.
  assign op_div    = div_mul_control[0] | div_mul_control[1];
  assign op_signed = div_mul_control[0] | (~div_mul_control[1] & div_mul_control[2]);
  assign mag1      = (op_signed && src1[31]) ? (~src1 + 32'd1) : src1;
  assign mag2      = (op_signed && src2[31]) ? (~src2 + 32'd1) : src2;

  // Divide datapath for one iteration and the signed/zero fix-up of the final result.
  always_comb begin
    rem_sh   = acc_q[63:31];
    diff     = rem_sh - {1'b0, b_q};
    div_next = diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                        : {diff[31:0], acc_q[30:0], 1'b1};
    quot_res = neg_q ? (~div_next[31:0] + 32'd1) : div_next[31:0];
    rem_res  = rneg_q ? (~div_next[63:32] + 32'd1) : div_next[63:32];
    if (dz_q) begin
      quot_res = 32'hFFFF_FFFF;
      rem_res  = raw_q;
    end
  end

`ifdef MDU_FAST_MUL_EN
  assign ext1 = op_signed ? {{32{src1[31]}}, src1} : {32'd0, src1};
  assign ext2 = op_signed ? {{32{src2[31]}}, src2} : {32'd0, src2};
`else
  // Multiply datapath: add multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole accumulator right by one.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};
    mul_res  = neg_q ? (~mul_next + 64'd1) : mul_next;
  end
`endif

  // Next-state logic: accept, iterate, commit, and mthi/mtlo writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    raw_d   = raw_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          b_d     = mag2;
          raw_d   = src1;
          neg_d   = op_signed & (src1[31] ^ src2[31]);
          rneg_d  = op_signed & src1[31];
          dz_d    = op_div & (src2 == 32'd0);
          cnt_d   = 5'd0;
          state_d = op_div ? StDiv : StMul;
`ifdef MDU_FAST_MUL_EN
          acc_d   = op_div ? {32'd0, mag1} : (ext1 * ext2);
`else
          acc_d   = {32'd0, mag1};
`endif
        end else if (issue_valid) begin
          if (hi_lo_control[0]) hi_d = src1;
          if (hi_lo_control[1]) lo_d = src1;
        end
      end
      StMul: begin
`ifdef MDU_FAST_MUL_EN
        hi_d    = acc_q[63:32];
        lo_d    = acc_q[31:0];
        state_d = StIdle;
`else
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = mul_res[63:32];
          lo_d    = mul_res[31:0];
          state_d = StIdle;
        end
`endif
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = rem_res;
          lo_d    = quot_res;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      b_q     <= 32'd0;
      raw_q   <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      raw_q   <= raw_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // mfhi/mflo read path; suppressed when a mul/div opcode is present.
  always_comb begin
    mf_data = 32'd0;
    if (!any_op) begin
      if (mf_sel[1])      mf_data = hi_q;
      else if (mf_sel[0]) mf_data = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl: directed cases from the test plan plus a random
// phase, all compared every cycle against an arithmetic model of HI/LO and busy timing.
module tb_mdu_hilo_ctrl;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 32;
`endif
  localparam int DivLat = 32;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  div_mul_control;
  logic [1:0]  hi_lo_control;
  logic [1:0]  mf_sel;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        stall;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_hilo_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .div_mul_control(div_mul_control),
    .hi_lo_control  (hi_lo_control),
    .mf_sel         (mf_sel),
    .src1           (src1),
    .src2           (src2),
    .busy           (busy),
    .stall          (stall),
    .mf_data        (mf_data),
    .hi             (hi),
    .lo             (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Model state: architectural HI/LO, cycles left until commit, pending result.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  logic [63:0] m_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op[0] || op[1]) begin
      if (b == 32'd0) begin
        res = {a, 32'hFFFF_FFFF};
      end else if (op[0]) begin
        sq  = sa / sb;
        sr  = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end else begin
        uq  = ua / ub;
        ur  = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
    end else if (op[2]) begin
      sq  = sa * sb;
      res = sq;
    end else begin
      uq  = ua * ub;
      res = uq;
    end
    return res;
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_edge();
    if (reset) begin
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (issue_valid && div_mul_control != 4'd0) begin
      m_pend = ref_result(div_mul_control, src1, src2);
      m_left = (div_mul_control[1:0] != 2'b00) ? DivLat : MulLat;
    end else if (issue_valid) begin
      if (hi_lo_control[0]) m_hi = src1;
      if (hi_lo_control[1]) m_lo = src1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [3:0] dmc, input logic [1:0] hlc,
                        input logic [1:0] mfs, input logic [31:0] a, input logic [31:0] b);
    issue_valid     = iv;
    div_mul_control = dmc;
    hi_lo_control   = hlc;
    mf_sel          = mfs;
    src1            = a;
    src2            = b;
  endtask

  // Issue one mul/div, then idle until it completes; reports busy cycle count.
  task automatic run_op(input string name, input logic [3:0] dmc, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles);
    int n;
    set_in(1'b1, dmc, 2'b00, 2'b00, a, b);
    tick();
    set_in(1'b0, 4'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check({name, " busy cycles"}, n, exp_cycles);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_busy;
      logic        e_stall;
      logic [31:0] e_mf;
      e_busy  = (m_left != 0);
      e_stall = issue_valid && e_busy &&
                (div_mul_control != 0 || hi_lo_control != 0 || mf_sel != 0);
      e_mf    = (div_mul_control != 0) ? 32'd0 :
                mf_sel[1] ? m_hi : mf_sel[0] ? m_lo : 32'd0;
      check("busy", busy, e_busy);
      check("stall", stall, e_stall);
      check("mf_data", mf_data, e_mf);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_left = 0;
    m_pend = 64'd0;
    reset  = 1'b1;
    set_in(1'b0, 4'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    tick();
    tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", busy, 1'b0);

    // mult -2 * 3, then mflo stalled until completion, then mfhi.
    set_in(1'b1, 4'b0100, 2'b00, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    tick();
    set_in(1'b1, 4'd0, 2'b00, 2'b01, 32'd0, 32'd0);
    n = 0;
    #1;
    while (stall && n < 100) begin
      n++;
      tick();
      #1;
    end
    check("mult stall cycles", n, MulLat);
    check("mult mflo", mf_data, 32'hFFFF_FFFA);
    tick();
    set_in(1'b1, 4'd0, 2'b00, 2'b10, 32'd0, 32'd0);
    #1;
    check("mult mfhi", mf_data, 32'hFFFF_FFFF);
    check("model hi pin", m_hi, 32'hFFFF_FFFF);
    tick();

    // Signed and unsigned divide of -7 by 2.
    run_op("div", 4'b0001, 32'hFFFF_FFF9, 32'd2, DivLat);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);
    run_op("divu", 4'b0010, 32'hFFFF_FFF9, 32'd2, DivLat);
    check("divu lo", lo, 32'h7FFF_FFFC);
    check("divu hi", hi, 32'h0000_0001);
    check("model lo pin", m_lo, 32'h7FFF_FFFC);

    // Divide by zero.
    run_op("divu0", 4'b0010, 32'h1234_5678, 32'd0, DivLat);
    check("dz lo", lo, 32'hFFFF_FFFF);
    check("dz hi", hi, 32'h1234_5678);

    // mthi then mfhi next cycle.
    set_in(1'b1, 4'd0, 2'b01, 2'b00, 32'hA5A5_A5A5, 32'd0);
    tick();
    set_in(1'b1, 4'd0, 2'b00, 2'b10, 32'd0, 32'd0);
    #1;
    check("mthi->mfhi", mf_data, 32'hA5A5_A5A5);
    check("mfhi stall", stall, 1'b0);
    tick();

    // Non-HI/LO instruction during a busy divide.
    set_in(1'b1, 4'b0001, 2'b00, 2'b00, 32'd100, 32'd7);
    tick();
    set_in(1'b1, 4'd0, 2'b00, 2'b00, 32'd1, 32'd2);
    #1;
    check("addu no stall", stall, 1'b0);
    check("addu busy", busy, 1'b1);
    set_in(1'b0, 4'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("div 100/7 lo", lo, 32'd14);
    check("div 100/7 hi", hi, 32'd2);

    // Reset at iteration 10 of a divide.
    set_in(1'b1, 4'b0001, 2'b00, 2'b00, 32'h0000_1000, 32'd3);
    tick();
    set_in(1'b0, 4'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    run_op("mult6x7", 4'b0100, 32'd6, 32'd7, MulLat);
    check("6x7 lo", lo, 32'd42);
    check("6x7 hi", hi, 32'd0);

    // Random phase.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      set_in($urandom_range(0, 3) != 0,
             ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0,
             ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0,
             2'($urandom), pick_val(), pick_val());
      tick();
    end
    reset = 1'b0;
    set_in(1'b0, 4'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_hilo_ctrl.md
# mdu_hilo_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the single-issue MIPS core. It is driven by the decoder's `div_mul_control`, `hi_lo_control` and the mfhi/mflo bits of `wbrf_mux_control`. It runs mult/multu/div/divu iteratively, commits results to HI/LO, and raises `stall` to hold the EX stage whenever an HI/LO-dependent instruction meets a busy unit. It sits beside the ALU in EX and replaces any combinational mul/div path.

## Interface
- None: no parameters; data width fixed at 32.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: EX holds a valid instruction this cycle.
- `div_mul_control` in 4: {multu, mult, divu, div}, decoder one-hot.
- `hi_lo_control` in 2: {mtlo, mthi}.
- `mf_sel` in 2: {mfhi, mflo} (= `wbrf_mux_control[3:2]`).
- `src1`, `src2` in 32 each: rs / rt operand values.
- `busy` out 1: operation in flight.
- `stall` out 1: hold EX/upstream this cycle.
- `mf_data` out 32: HI if mfhi, LO if mflo, else 0.
- `hi`, `lo` out 32 each: architectural HI/LO registers.

## Operation
- Opcode priority if multi-hot: div > divu > mult > multu; hi_lo/mf bits are ignored while any div_mul bit is set.
- States:
  - IDLE: `busy`=0.
  - MUL and DIV: `busy`=1, 5-bit iteration counter `cnt`.
- IDLE to MUL/DIV on accept, i.e. `issue_valid && |div_mul_control && !busy`. Operands are latched, `cnt`=0.
- Signed ops convert to magnitudes at accept and record the signs. Unsigned ops use the operands as-is.
- DIV: restoring radix-2, one quotient bit per cycle, 32 iterations.
  - Quotient sign = s1^s2; remainder sign = s1.
  - Divide by zero: LO=0xFFFFFFFF, HI=src1 (raw dividend), for both div and divu. Latency is unchanged.
- MUL (macro off): shift-add, one multiplier bit per cycle, 32 iterations, 64-bit accumulator. Signed result is negated if s1^s2.
- Completion at the `cnt`==31 edge: HI := high word/remainder, LO := low word/quotient, state goes to IDLE.
- mthi/mtlo: when `issue_valid && !busy`, write `src1` into HI/LO at the edge.
- mfhi/mflo: `mf_data` is combinational from the current `hi`/`lo`.
- `stall = issue_valid && busy && (|div_mul_control || |hi_lo_control || |mf_sel)`. Non-HI/LO instructions never stall.
- Reset (including mid-operation): state IDLE, `cnt`=0, `hi`=`lo`=0, `busy`=0, `stall`=0, `mf_data`=0. Any in-flight result is discarded.

## Timing
- Accept at edge E0. `busy`=1 from E0 through E32 (32 cycles, or 1 cycle with fast multiply). HI/LO are updated at E32, and `busy`=0 in the cycle after E32.
- The cycle containing E32 still has `busy`=1, so a dependent instruction stalls through it. It reads the new HI/LO in the next cycle, so a completing write and a new read never collide.
- A new mul/div presented in the completion cycle is stalled and accepted one cycle later. There is no back-to-back overlap.
- mthi/mtlo followed by mfhi/mflo in the next cycle returns the written value.
- `stall` and `mf_data` are combinational from state plus inputs. All other outputs are registered.

## Configuration
- `MDU_FAST_MUL_EN` defined: mult/multu compute the 64-bit product with a single-cycle `*`. MUL lasts 1 cycle, and HI/LO are written at E1. Divide is unchanged.
- Not defined: mult/multu take the 32-iteration shift-add path with the same timing as divide.

## Test plan
- Signed multiply: mult, src1=0xFFFFFFFE (-2), src2=0x00000003, then mflo and mfhi.
  - Expect HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Expect `stall` high for exactly 32 cycles (1 with `MDU_FAST_MUL_EN`).
- Signed divide: div, src1=0xFFFFFFF9 (-7), src2=2.
  - Expect LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - divu on the same operands: LO=0x7FFFFFFC, HI=0x00000001.
- Divide by zero: divu, src1=0x12345678, src2=0.
  - Expect LO=0xFFFFFFFF, HI=0x12345678 after 32 busy cycles.
- Move then read: mthi 0xA5A5A5A5, then mfhi next cycle.
  - Expect `mf_data`=0xA5A5A5A5 with no stall.
  - Then issue an addu during a busy divide: expect `stall`=0.
- Reset mid-divide: assert `reset` at iteration 10 of a divide.
  - Expect next cycle `busy`=0, `hi`=`lo`=0.
  - A following mult 6×7 yields LO=42, HI=0.
